curr_mem_ctrl: RTL



---
 rtl/acc_pkg.sv | 20 ++
 rtl/curr_mem_addr_gen.sv | 80 ++++++++
 rtl/curr_mem_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared types and default geometry for the current-block memory controller
package acc_pkg;

  localparam int IMG_DIM_DEF = 16;
  localparam int TILE_DEF    = 4;
  localparam int PIX_CNT     = IMG_DIM_DEF * IMG_DIM_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SCAN = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // A range of one value still needs a one-bit counter.
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

endpackage

// File: rtl/curr_mem_addr_gen.sv
// rtl/curr_mem_addr_gen.sv - nested tile/pixel scan counters and read address for the tiled scan
module curr_mem_addr_gen
  import acc_pkg::*;
#(
  parameter int IMG_DIM = IMG_DIM_DEF,
  parameter int TILE    = TILE_DEF,
  parameter int AW      = $clog2(PIX_CNT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [AW-1:0] addr_o,
  output logic          tile_last_o,
  output logic          frame_last_o
);

  localparam int NT = IMG_DIM / TILE;
  localparam int PW = cnt_w(TILE);
  localparam int TW = cnt_w(NT);
  localparam int TB = $clog2(TILE);
  localparam int IB = $clog2(IMG_DIM);

  logic [PW-1:0] px_q, px_d, py_q, py_d;
  logic [TW-1:0] tx_q, tx_d, ty_q, ty_d;
  logic          px_max, py_max, tx_max, ty_max;
  logic [AW-1:0] row, col;

  assign px_max = (px_q == PW'(TILE - 1));
  assign py_max = (py_q == PW'(TILE - 1));
  assign tx_max = (tx_q == TW'(NT - 1));
  assign ty_max = (ty_q == TW'(NT - 1));

  assign tile_last_o  = px_max & py_max;
  assign frame_last_o = tile_last_o & tx_max & ty_max;

  // Power-of-two geometry: the multiplies reduce to shifts.
  assign row    = (AW'(ty_q) << TB) + AW'(py_q);
  assign col    = (AW'(tx_q) << TB) + AW'(px_q);
  assign addr_o = (row << IB) + col;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    tx_d = tx_q;
    ty_d = ty_q;
    if (clear_i) begin
      px_d = '0;
      py_d = '0;
      tx_d = '0;
      ty_d = '0;
    end else if (advance_i) begin
      px_d = px_max ? '0 : px_q + 1'b1;
      if (px_max) begin
        py_d = py_max ? '0 : py_q + 1'b1;
        if (py_max) begin
          tx_d = tx_max ? '0 : tx_q + 1'b1;
          if (tx_max) begin
            ty_d = ty_max ? '0 : ty_q + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      px_q <= '0;
      py_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
    end else begin
      px_q <= px_d;
      py_q <= py_d;
      tx_q <= tx_d;
      ty_q <= ty_d;
    end
  end

endmodule

// File: rtl/curr_mem_ctrl.sv
// rtl/curr_mem_ctrl.sv - loads the current block from a host byte stream and scans it out as tiled pixels
module curr_mem_ctrl
  import acc_pkg::*;
#(
  parameter int IMG_DIM = IMG_DIM_DEF,
  parameter int TILE    = TILE_DEF,
  parameter int AW      = $clog2(PIX_CNT)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          load_start_i,
  input  logic          scan_start_i,
  input  logic          wr_valid_i,
  input  logic [7:0]    wr_data_i,
  output logic          wr_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [7:0]    mem_wdata_o,
  output logic [AW-1:0] mem_raddr_o,
  input  logic [7:0]    mem_rdata_i,
  output logic          pix_valid_o,
  input  logic          pix_ready_i,
  output logic [7:0]    pix_data_o,
  output logic          tile_last_o,
  output logic          frame_last_o,
  output logic          busy_o,
  output logic          done_o
);

  localparam int NPIX = IMG_DIM * IMG_DIM;

  state_e        state_q, state_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic          wr_fire, pix_fire;
  logic          tile_last, frame_last;
  logic [AW-1:0] scan_addr;

  assign wr_fire  = (state_q == ST_LOAD) & wr_valid_i;
  assign pix_fire = (state_q == ST_SCAN) & pix_ready_i;

  // Scan counters sit at zero whenever no scan is running, so raddr idles at 0.
  curr_mem_addr_gen #(
    .IMG_DIM (IMG_DIM),
    .TILE    (TILE),
    .AW      (AW)
  ) u_addr_gen (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (state_q != ST_SCAN),
    .advance_i    (pix_fire),
    .addr_o       (scan_addr),
    .tile_last_o  (tile_last),
    .frame_last_o (frame_last)
  );

  assign wr_ready_o   = (state_q == ST_LOAD);
  assign mem_we_o     = wr_fire;
  assign mem_waddr_o  = wcnt_q;
  assign mem_wdata_o  = wr_data_i;
  assign mem_raddr_o  = scan_addr;
  assign pix_valid_o  = (state_q == ST_SCAN);
  assign pix_data_o   = mem_rdata_i;
  assign tile_last_o  = pix_valid_o & tile_last;
  assign frame_last_o = pix_valid_o & frame_last;
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_start_i) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
        end else if (scan_start_i) begin
          state_d = ST_SCAN;
        end
      end
      ST_LOAD: begin
        if (wr_fire) begin
          if (wcnt_q == AW'(NPIX - 1)) begin
            wcnt_d  = '0;
            state_d = ST_DONE;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_SCAN: begin
        if (pix_fire & frame_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

endmodule
